// File: rtl/triangle_assembler_pkg.sv
// Shared graphics types for the triangle assembler: vertex/triangle records,
// field widths and the vertex slot encoding.
package triangle_assembler_pkg;

   localparam int MATERIAL_W = 12;
   localparam int ID_W       = 16;
   localparam int COORD_W    = 32;

   typedef logic [2:0][COORD_W-1:0] vec3_t;

   typedef struct packed {
      vec3_t                 position;
      vec3_t                 normal;
      logic [ID_W-1:0]       vertex_id;
      logic [MATERIAL_W-1:0] material;
   } vertex_t;

   // vert[0] is the first vertex to arrive.
   typedef struct packed {
      vertex_t [2:0]   vert;
      logic [ID_W-1:0] tri_id;
   } triangle_t;

   typedef enum logic [1:0] {
      SLOT_0 = 2'd0,
      SLOT_1 = 2'd1,
      SLOT_2 = 2'd2
   } slot_e;

endpackage

// File: rtl/triangle_fifo.sv
// Synchronous FIFO with registered storage and fall-through read port.
// A push while full is accepted only when a pop happens in the same cycle.
module triangle_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             push_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full_out,
   output logic             empty_out
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   assign empty_out = (count_q == '0);
   assign full_out  = (count_q == (AW+1)'(DEPTH));
   assign rd_en     = pop_in && !empty_out;
   assign wr_en     = push_in && (!full_out || rd_en);
   assign data_out  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !rd_en) count_d = count_q + (AW+1)'(1);
      else if (rd_en && !wr_en) count_d = count_q - (AW+1)'(1);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_in;
   end

endmodule

// File: rtl/triangle_assembler.sv
// Groups streaming vertices into triangles of three and queues them for a
// ready/valid consumer; triangles that find the queue full are dropped.
module triangle_assembler
   import triangle_assembler_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         valid_in,
   input  logic [ID_W-1:0]              vertex_id_in,
   input  logic [2:0][COORD_W-1:0]      position_in,
   input  logic [2:0][COORD_W-1:0]      normal_in,
   input  logic [MATERIAL_W-1:0]        material_in,
   input  logic                         flush_in,
   output logic                         valid_out,
   input  logic                         ready_in,
   output logic [2:0][2:0][COORD_W-1:0] position_out,
   output logic [2:0][2:0][COORD_W-1:0] normal_out,
   output logic [2:0][ID_W-1:0]         vertex_ids_out,
   output logic [MATERIAL_W-1:0]        material_out,
   output logic [ID_W-1:0]              tri_id_out,
   output logic                         overflow_out,
   output logic [ID_W-1:0]              triangle_count_out
);

   slot_e           slot_q, slot_d;
   vertex_t         slot0_q, slot1_q;
   vertex_t         vtx_in;
   triangle_t       push_tri, head_tri;
   logic [ID_W-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            take, push, pop, accept, drop;
   logic            fifo_full, fifo_empty;

   assign vtx_in = '{position: position_in, normal: normal_in,
                     vertex_id: vertex_id_in, material: material_in};

   assign take   = valid_in && !flush_in;
   assign push   = take && (slot_q == SLOT_2);
   assign pop    = !fifo_empty && ready_in;
   assign accept = push && (!fifo_full || pop);
   assign drop   = push && fifo_full && !pop;

   assign push_tri = '{vert: {vtx_in, slot1_q, slot0_q}, tri_id: count_q};

   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (flush_in) begin
         slot_d = SLOT_0;
      end else if (valid_in) begin
         case (slot_q)
            SLOT_0:  slot_d = SLOT_1;
            SLOT_1:  slot_d = SLOT_2;
            default: slot_d = SLOT_0;
         endcase
      end
      if (accept) count_d = count_q + 1'b1;
      if (drop)   ovf_d   = 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         slot_q  <= SLOT_0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Partial-triangle storage carries no reset; slot_q alone says what is valid.
   always_ff @(posedge clk_in) begin
      if (take && (slot_q == SLOT_0)) slot0_q <= vtx_in;
      if (take && (slot_q == SLOT_1)) slot1_q <= vtx_in;
   end

   triangle_fifo #(
      .WIDTH ($bits(triangle_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .push_in   (accept),
      .data_in   (push_tri),
      .pop_in    (pop),
      .data_out  (head_tri),
      .full_out  (fifo_full),
      .empty_out (fifo_empty)
   );

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         position_out[k]   = head_tri.vert[k].position;
         normal_out[k]     = head_tri.vert[k].normal;
         vertex_ids_out[k] = head_tri.vert[k].vertex_id;
      end
   end

   assign valid_out          = !fifo_empty;
   assign material_out       = head_tri.vert[0].material;
   assign tri_id_out         = head_tri.tri_id;
   assign overflow_out       = ovf_q;
   assign triangle_count_out = count_q;

endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: directed vector table, corner-case sequences
// and random traffic against a queue-based reference model.
module tb_triangle_assembler;
   import triangle_assembler_pkg::*;

   localparam int DEPTH = 4;

   logic                  clk_in = 1'b0;
   logic                  rst_n_in = 1'b0;
   logic                  valid_in = 1'b0;
   logic [15:0]           vertex_id_in = '0;
   logic [2:0][31:0]      position_in = '0;
   logic [2:0][31:0]      normal_in = '0;
   logic [11:0]           material_in = '0;
   logic                  flush_in = 1'b0;
   logic                  valid_out;
   logic                  ready_in = 1'b0;
   logic [2:0][2:0][31:0] position_out;
   logic [2:0][2:0][31:0] normal_out;
   logic [2:0][15:0]      vertex_ids_out;
   logic [11:0]           material_out;
   logic [15:0]           tri_id_out;
   logic                  overflow_out;
   logic [15:0]           triangle_count_out;

   always #5 clk_in = ~clk_in;

   triangle_assembler #(.DEPTH(DEPTH)) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .valid_in           (valid_in),
      .vertex_id_in       (vertex_id_in),
      .position_in        (position_in),
      .normal_in          (normal_in),
      .material_in        (material_in),
      .flush_in           (flush_in),
      .valid_out          (valid_out),
      .ready_in           (ready_in),
      .position_out       (position_out),
      .normal_out         (normal_out),
      .vertex_ids_out     (vertex_ids_out),
      .material_out       (material_out),
      .tri_id_out         (tri_id_out),
      .overflow_out       (overflow_out),
      .triangle_count_out (triangle_count_out)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pending vertex ids, a bounded triangle queue, counters.
   typedef struct {
      logic [15:0]      tid;
      logic [2:0][15:0] ids;
   } mtri_t;

   mtri_t       mq[$];
   logic [15:0] pend[$];
   logic [15:0] mcnt = '0;
   logic        movf = 1'b0;

   function automatic logic [2:0][31:0] pos_of(input logic [15:0] id);
      for (int k = 0; k < 3; k++) pos_of[k] = {8'hA0, 8'(k), id};
   endfunction

   function automatic logic [2:0][31:0] nrm_of(input logic [15:0] id);
      for (int k = 0; k < 3; k++) nrm_of[k] = {8'hB0, 8'(k), ~id};
   endfunction

   function automatic logic [11:0] mat_of(input logic [15:0] id);
      return id[11:0] ^ 12'h5A5;
   endfunction

   task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outputs();
      logic [2:0][2:0][31:0] ep, en;
      chk("valid_out", valid_out, mq.size() > 0);
      chk("triangle_count", triangle_count_out, mcnt);
      chk("overflow", overflow_out, movf);
      if (mq.size() > 0) begin
         for (int k = 0; k < 3; k++) begin
            ep[k] = pos_of(mq[0].ids[k]);
            en[k] = nrm_of(mq[0].ids[k]);
         end
         chk("vertex_ids", vertex_ids_out, mq[0].ids);
         chk("tri_id", tri_id_out, mq[0].tid);
         chk("material", material_out, mat_of(mq[0].ids[0]));
         chk("position", position_out, ep);
         chk("normal", normal_out, en);
      end
   endtask

   // One clock: drive inputs, advance the model, sample 1 unit after the edge.
   task automatic cycle(input logic v, input logic [15:0] id, input logic f, input logic r);
      logic  full, pop;
      mtri_t t;
      valid_in     = v;
      vertex_id_in = id;
      position_in  = pos_of(id);
      normal_in    = nrm_of(id);
      material_in  = mat_of(id);
      flush_in     = f;
      ready_in     = r;
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && r;
      if (pop) void'(mq.pop_front());
      if (f) begin
         pend.delete();
      end else if (v) begin
         pend.push_back(id);
         if (pend.size() == 3) begin
            t.ids = {pend[2], pend[1], pend[0]};
            t.tid = mcnt;
            pend.delete();
            if (!full || pop) begin
               mq.push_back(t);
               mcnt++;
            end else begin
               movf = 1'b1;
            end
         end
      end
      @(posedge clk_in);
      #1;
      check_outputs();
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset();
      valid_in = 1'b0;
      flush_in = 1'b0;
      ready_in = 1'b0;
      rst_n_in = 1'b0;
      #1;
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_count", triangle_count_out, 16'd0);
      chk("rst_overflow", overflow_out, 1'b0);
      mq.delete();
      pend.delete();
      mcnt = '0;
      movf = 1'b0;
      #1;
      rst_n_in = 1'b1;
   endtask

   typedef struct {
      logic        v;
      logic [15:0] id;
      logic        f;
      logic        r;
      logic        ev;
      logic [47:0] eids;
      logic [15:0] etid;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic v, f, r;

      tbl[0]  = '{1'b1, 16'd0,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd0};
      tbl[1]  = '{1'b1, 16'd1,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd0};
      tbl[2]  = '{1'b1, 16'd2,   1'b0, 1'b1, 1'b1, {16'd2, 16'd1, 16'd0}, 16'd0, 16'd1};
      tbl[3]  = '{1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd1};
      tbl[4]  = '{1'b1, 16'd0,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd1};
      tbl[5]  = '{1'b1, 16'd1,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd1};
      tbl[6]  = '{1'b1, 16'h55,  1'b1, 1'b1, 1'b0, 48'd0, 16'd0, 16'd1};
      tbl[7]  = '{1'b1, 16'd7,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd1};
      tbl[8]  = '{1'b1, 16'd8,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd1};
      tbl[9]  = '{1'b1, 16'd9,   1'b0, 1'b1, 1'b1, {16'd9, 16'd8, 16'd7}, 16'd1, 16'd2};
      tbl[10] = '{1'b0, 16'd0,   1'b0, 1'b1, 1'b0, 48'd0, 16'd0, 16'd2};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].v, tbl[i].id, tbl[i].f, tbl[i].r);
         chk("tbl_valid", valid_out, tbl[i].ev);
         chk("tbl_count", triangle_count_out, tbl[i].ecnt);
         if (tbl[i].ev) begin
            chk("tbl_ids", vertex_ids_out, tbl[i].eids);
            chk("tbl_tri_id", tri_id_out, tbl[i].etid);
         end
      end

      // Backpressure: first triangle held stable for 10 cycles.
      do_reset();
      for (int i = 0; i < 6; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 16'd0, 1'b0, 1'b0);
         chk("hold_tri_id", tri_id_out, 16'd0);
         chk("hold_ids", vertex_ids_out, {16'd2, 16'd1, 16'd0});
      end
      cycle(1'b0, 16'd0, 1'b0, 1'b1);
      chk("second_tri_id", tri_id_out, 16'd1);
      chk("second_ids", vertex_ids_out, {16'd5, 16'd4, 16'd3});
      cycle(1'b0, 16'd0, 1'b0, 1'b1);
      chk("drained_valid", valid_out, 1'b0);

      // Overflow: 15 vertices, no consumer.
      do_reset();
      for (int i = 0; i < 14; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
      chk("ovf_before_5th", overflow_out, 1'b0);
      cycle(1'b1, 16'd14, 1'b0, 1'b0);
      chk("ovf_after_5th", overflow_out, 1'b1);
      chk("ovf_count", triangle_count_out, 16'd4);
      for (int j = 0; j < 4; j++) begin
         chk("ovf_drain_ids", vertex_ids_out, {16'(3*j+2), 16'(3*j+1), 16'(3*j)});
         cycle(1'b0, 16'd0, 1'b0, 1'b1);
      end
      chk("ovf_drain_empty", valid_out, 1'b0);
      chk("ovf_sticky", overflow_out, 1'b1);

      // Full FIFO with push and pop in the same cycle.
      do_reset();
      for (int i = 0; i < 12; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
      chk("full_count", triangle_count_out, 16'd4);
      cycle(1'b1, 16'd12, 1'b0, 1'b0);
      cycle(1'b1, 16'd13, 1'b0, 1'b0);
      cycle(1'b1, 16'd14, 1'b0, 1'b1);
      chk("pushpop_ovf", overflow_out, 1'b0);
      chk("pushpop_count", triangle_count_out, 16'd5);
      for (int j = 1; j < 5; j++) begin
         chk("pushpop_order", vertex_ids_out, {16'(3*j+2), 16'(3*j+1), 16'(3*j)});
         chk("pushpop_tri_id", tri_id_out, 16'(j));
         cycle(1'b0, 16'd0, 1'b0, 1'b1);
      end
      chk("pushpop_empty", valid_out, 1'b0);

      // Reset mid-operation with a queued triangle and a partial one.
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'd0, 1'b0, 1'b0);
      cycle(1'b1, 16'd1, 1'b0, 1'b0);
      chk("pre_rst_valid", valid_out, 1'b1);
      do_reset();
      cycle(1'b1, 16'd4, 1'b0, 1'b1);
      cycle(1'b1, 16'd5, 1'b0, 1'b1);
      cycle(1'b1, 16'd6, 1'b0, 1'b1);
      chk("post_rst_ids", vertex_ids_out, {16'd6, 16'd5, 16'd4});
      chk("post_rst_tri_id", tri_id_out, 16'd0);
      cycle(1'b0, 16'd0, 1'b0, 1'b1);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         v = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 19) == 0);
         r = (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         cycle(v, 16'($urandom), f, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 4: triangle FIFO entries; power of two, at least 2.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port valid_in, input, 1 bit: a vertex is present this cycle; there is no backpressure to the source.
REQ-005 SHALL have port vertex_id_in, input, 16 bits: vertex index.
REQ-006 SHALL have port position_in, input, 3x32 bits: x, y, z.
REQ-007 SHALL have port normal_in, input, 3x32 bits: nx, ny, nz.
REQ-008 SHALL have port material_in, input, 12 bits: material id.
REQ-009 SHALL have port flush_in, input, 1 bit: discard any partially assembled triangle.
REQ-010 SHALL have port valid_out, output, 1 bit: a triangle is presented.
REQ-011 SHALL have port ready_in, input, 1 bit: the consumer accepts the presented triangle.
REQ-012 SHALL have port position_out, output, 3x3x32 bits: vertices v0, v1, v2 in arrival order.
REQ-013 SHALL have port normal_out, output, 3x3x32 bits: normals ordered as position_out.
REQ-014 SHALL have port vertex_ids_out, output, 3x16 bits: vertex ids ordered as position_out.
REQ-015 SHALL have port material_out, output, 12 bits: material of v0.
REQ-016 SHALL have port tri_id_out, output, 16 bits: sequence number of the presented triangle.
REQ-017 SHALL have port overflow_out, output, 1 bit: sticky flag, set when a triangle is dropped.
REQ-018 SHALL have port triangle_count_out, output, 16 bits: number of triangles accepted into the FIFO.

Function
REQ-019 SHALL keep a 2-bit slot counter, states 0, 1 and 2; each valid_in without flush_in stores the vertex in the slot given by the counter.
REQ-020 SHALL advance the slot counter on each stored vertex in slot 0 -> 1 -> 2; when the counter is 2, a valid_in pushes {slot0, slot1, incoming vertex} and returns the counter to 0.
REQ-021 SHALL, on flush_in, return the slot counter to 0 and discard any valid_in in the same cycle; flush_in has no effect on FIFO contents.
REQ-022 SHALL present a pushed triangle on valid_out in the cycle after the third vertex's valid_in when the FIFO was empty (latency 1 cycle, first-word fall-through).
REQ-023 SHALL set valid_out = FIFO not empty and pop the FIFO on valid_out && ready_in.
REQ-024 SHALL hold every output field stable while valid_out && !ready_in.
REQ-025 SHALL, when a push occurs with the FIFO full and no pop in the same cycle, drop the triangle, set overflow_out, leave triangle_count_out unchanged and still return the slot counter to 0.
REQ-026 SHALL accept a push with the FIFO full when a pop occurs in the same cycle, with no drop.
REQ-027 SHALL handle a simultaneous push and pop on an empty FIFO as a push only, since valid_out is low.
REQ-028 SHALL set tri_id equal to triangle_count_out at the time of the accepted push, then increment triangle_count_out; the count wraps from 0xFFFF to 0.
REQ-029 SHALL hold overflow_out at 1 until reset.
REQ-030 SHALL leave data outputs don't-care while valid_out is 0.

Reset
REQ-031 SHALL, on rst_n_in low, immediately and asynchronously force: valid_out 0, overflow_out 0, triangle_count_out 0, slot counter 0, FIFO read and write pointers and occupancy 0.
REQ-032 SHALL lose any partial triangle and any FIFO contents on a reset mid-operation; the FIFO data array is not reset.
REQ-033 SHALL, on rst_n_in deassertion, accept a vertex in the first following clock edge.

Structure
REQ-034 SHALL define vertex_t {position, normal, vertex_id, material} and triangle_t {3x vertex_t, tri_id} in the shared graphics package, together with the 12-bit material width and 16-bit id width constants.
REQ-035 SHALL implement the FIFO as one sub-module, triangle_fifo (parameterized WIDTH and DEPTH, registered storage, fall-through read, full/empty outputs), with assembly logic in the top level.

Verification
REQ-036 SHALL verify: vertices ids 0, 1, 2 on three consecutive cycles, ready_in=1 -> one triangle with vertex_ids_out {0,1,2}, tri_id_out 0, valid_out high for 1 cycle starting the cycle after id 2, triangle_count_out 1.
REQ-037 SHALL verify: ids 0..5 back-to-back, ready_in=0 for 10 cycles then 1 -> tri_id 0 held stable, then tri_id 1, then valid_out low; ids {3,4,5} in the second triangle.
REQ-038 SHALL verify: ids 0, 1, then flush_in, then ids 7, 8, 9 -> single triangle {7,8,9}; no triangle containing 0 or 1.
REQ-039 SHALL verify: DEPTH=4, ready_in=0, 15 vertices -> 4 triangles held, overflow_out=1 after the 5th push, triangle_count_out 4, drained ids {0..11} in order.
REQ-040 SHALL verify: FIFO full with push and pop in the same cycle -> no overflow, count increments, order preserved.
REQ-041 SHALL verify: rst_n_in pulsed low after ids 0, 1 -> outputs zero without a clock edge, and the next ids 4, 5, 6 form the triangle {4,5,6} with tri_id 0.
